rf_writeback_arbiter: RTL and testbench
=======================================

Name: rf_writeback_arbiter

Overview:
Drives the register file's single write port (write enable, 5-bit address, 32-bit data). It merges two writeback sources onto that port: the single-cycle ALU result stream and the variable-latency load-response stream. A small load queue absorbs port conflicts. A 32-bit scoreboard tracks registers with an outstanding load, so the decode stage can stall on RAW/WAW hazards against in-flight loads.

Parameters:
XLEN, 32, data width of the write port and both sources
LQ_DEPTH, 2, load-response queue entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU result valid this cycle; no backpressure
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
ld_issue_valid  in  1  decode issues a load this cycle
ld_issue_rd  in  5  load destination register
ld_issue_ready  out  1  load may issue (destination not busy)
lresp_valid  in  1  load response valid
lresp_ready  out  1  queue can accept a response
lresp_rd  in  5  load response destination register
lresp_data  in  XLEN  load response data
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  5  register-file write address (registered)
rf_wdata  out  XLEN  register-file write data (registered)
busy  out  32  scoreboard; busy[r]=1 means a load to r is outstanding
lq_count  out  $clog2(LQ_DEPTH)+1  queued load responses
err_waw  out  1  sticky: ALU wrote a busy register

Behaviour:
- Reset (async, any time, including mid-drain): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, lq_count=0, err_waw=0, queue emptied; in-flight queued writes are dropped.
- Register x0: any source with rd=0 is discarded. It never asserts rf_we and never sets busy. busy[0] is constant 0.
- Write-port latency: exactly one cycle. Values selected in cycle N appear on rf_we/rf_waddr/rf_wdata after edge N+1, for one cycle only.
- Port priority each cycle, highest first:
  1. ALU (alu_valid && alu_rd!=0).
  2. Queue head, if lq_count>0.
  3. Bypass: a response accepted this cycle while the queue is empty goes straight to the port.
  4. Otherwise rf_we=0, and rf_waddr/rf_wdata hold their previous values.
- Load queue: in-order FIFO.
  - lresp_ready = (lq_count < LQ_DEPTH), computed from registered state only.
  - Accept occurs when lresp_valid && lresp_ready.
  - An accepted response is enqueued unless it took the bypass. It is also dropped if rd=0.
  - Simultaneous enqueue and dequeue leaves lq_count unchanged. Pointers wrap modulo LQ_DEPTH.
- Scoreboard:
  - ld_issue_ready = !busy[ld_issue_rd] (combinational). ld_issue_rd=0 is always ready.
  - Issue is ld_issue_valid && ld_issue_ready && rd!=0. It sets busy[rd] at the next edge.
  - busy[r] clears on the edge where a load write to r is registered onto the port.
  - Set and clear of the same r in one cycle: set wins.
- err_waw: set at the edge after the ALU writes a register whose busy bit is 1. It stays set until reset. The write still proceeds, and busy is not changed.
- Starvation: a continuous ALU stream may stall the queue indefinitely. lresp_ready deasserts when the queue is full; no ALU throttling.

Decomposition:
- Package rf_wb_pkg:
  - XLEN default and REG_AW=5.
  - Typedef wb_req_t {rd[4:0], data[XLEN-1:0]}.
  - Source-select enum SRC_NONE/SRC_ALU/SRC_LQ/SRC_BYP.
- One sub-module, wb_load_fifo: a parameterised synchronous FIFO with async reset. It exposes count, full, empty, head, push and pop. The scoreboard and arbitration stay in the top module.

Test Plan:
1. Reset check: assert rst mid-stream with 2 entries queued -> rf_we=0, lq_count=0, busy=0, lresp_ready=1 in the same cycle as rst.
2. Basic ALU write: alu_valid=1, rd=5, data=32'hDEADBEEF at cycle N -> rf_we=1, waddr=5, wdata=DEADBEEF after edge N+1; rf_we=0 the following cycle.
3. Load round trip:
   - Issue ld_issue_rd=7 -> busy[7]=1, and ld_issue_ready=0 for rd=7.
   - Then response rd=7, data=0x1234 with the queue empty and no ALU write -> bypass, rf_we for r7 one cycle later, and busy[7]=0 on that same edge.
4. Collision and queue-full:
   - ALU writes every cycle while responses rd=3, 4, 6 arrive back-to-back -> lq_count reaches 2 and lresp_ready=0.
   - The third response is held by its source.
   - After ALU stops, writes to r3, r4, r6 follow in order on consecutive cycles.
5. x0 and hazard checks:
   - ALU rd=0 and a load response rd=0 -> no rf_we, busy[0]=0.
   - ALU write to r9 while busy[9]=1 -> err_waw=1 next cycle and stays high.
6. Same-cycle set and clear: a load write to r2 drains in the same cycle a new load with rd=2 issues -> busy[2] remains 1.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   XLEN_DEF : default data width of the write port
//   REG_AW   : register address width (32 architectural registers)
//   wb_req_t : one writeback request (destination + data)
//   wb_src_e : which source owns the write port in a given cycle
package rf_wb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_AW   = 5;

    typedef struct packed {
        logic [REG_AW-1:0]   rd;
        logic [XLEN_DEF-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LQ,
        SRC_BYP
    } wb_src_e;

endpackage

// File: rtl/wb_load_fifo.sv
// In-order FIFO holding load responses that lost the write port.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push/din : enqueue din (ignored when full)
//   pop      : dequeue the head entry (ignored when empty)
//   head     : current head entry, valid when !empty
//   count    : number of stored entries
//   full     : count == DEPTH
//   empty    : count == 0
module wb_load_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset: entries are only ever read once count says they exist.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges the ALU result stream and the load-response stream onto the
// register file's single write port, and keeps a scoreboard of registers
// with an outstanding load.
//   clk, rst                  : clock, asynchronous active-high reset
//   alu_valid/rd/data         : ALU writeback, no backpressure, highest priority
//   ld_issue_valid/rd, ready  : load issue from decode; ready = destination not busy
//   lresp_valid/ready/rd/data : load response stream, buffered in a small queue
//   rf_we/waddr/wdata         : registered write port (one cycle latency)
//   busy                      : scoreboard, busy[r]=1 while a load to r is outstanding
//   lq_count                  : number of queued load responses
//   err_waw                   : sticky flag, ALU wrote a register with a pending load
module rf_writeback_arbiter
    import rf_wb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int LQ_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    input  logic [REG_AW-1:0]         alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      ld_issue_valid,
    input  logic [REG_AW-1:0]         ld_issue_rd,
    output logic                      ld_issue_ready,
    input  logic                      lresp_valid,
    output logic                      lresp_ready,
    input  logic [REG_AW-1:0]         lresp_rd,
    input  logic [XLEN-1:0]           lresp_data,
    output logic                      rf_we,
    output logic [REG_AW-1:0]         rf_waddr,
    output logic [XLEN-1:0]           rf_wdata,
    output logic [31:0]               busy,
    output logic [$clog2(LQ_DEPTH):0] lq_count,
    output logic                      err_waw
);

    localparam int EW = REG_AW + XLEN;

    logic              alu_ok;
    logic              accept;
    logic              issue;
    logic              lq_full;
    logic              lq_empty;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_data;
    wb_src_e           src;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic              load_wr;
    logic [31:0]       busy_nxt;

    assign alu_ok      = alu_valid && (alu_rd != '0);
    assign lresp_ready = !lq_full;
    assign accept      = lresp_valid && lresp_ready;
    assign head_rd     = head[EW-1:XLEN];
    assign head_data   = head[XLEN-1:0];

    // busy[0] is held at zero, so x0 always reads as ready.
    assign ld_issue_ready = !busy[ld_issue_rd];
    assign issue          = ld_issue_valid && ld_issue_ready && (ld_issue_rd != '0);

    // Port owner for this cycle. Bypass is only reachable with the queue
    // empty, which keeps load writes in arrival order.
    always_comb begin
        src = SRC_NONE;
        if (alu_ok) begin
            src = SRC_ALU;
        end else if (!lq_empty) begin
            src = SRC_LQ;
        end else if (accept && (lresp_rd != '0)) begin
            src = SRC_BYP;
        end
    end

    always_comb begin
        sel_rd   = rf_waddr;
        sel_data = rf_wdata;
        load_wr  = 1'b0;
        case (src)
            SRC_ALU: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
            SRC_LQ: begin
                sel_rd   = head_rd;
                sel_data = head_data;
                load_wr  = 1'b1;
            end
            SRC_BYP: begin
                sel_rd   = lresp_rd;
                sel_data = lresp_data;
                load_wr  = 1'b1;
            end
            default: begin
                sel_rd   = rf_waddr;
                sel_data = rf_wdata;
            end
        endcase
    end

    // Responses to x0 are accepted (to free the source) but never stored.
    assign push = accept && (lresp_rd != '0) && (src != SRC_BYP);
    assign pop  = (src == SRC_LQ);

    // A load write clears its bit; a new issue to the same register in the
    // same cycle must win, so the set is applied last.
    always_comb begin
        busy_nxt = busy;
        if (load_wr) begin
            busy_nxt[sel_rd] = 1'b0;
        end
        if (issue) begin
            busy_nxt[ld_issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    wb_load_fifo #(
        .WIDTH (EW),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({lresp_rd, lresp_data}),
        .pop   (pop),
        .head  (head),
        .count (lq_count),
        .full  (lq_full),
        .empty (lq_empty)
    );

    // Registered write port, scoreboard and sticky hazard flag. Address and
    // data hold their last values on idle cycles; only rf_we pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= '0;
            err_waw  <= 1'b0;
        end else begin
            rf_we    <= (src != SRC_NONE);
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
            busy     <= busy_nxt;
            if (alu_ok && busy[alu_rd]) begin
                err_waw <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: directed scenarios followed
// by a randomized phase, all compared against a queue-based reference model.
module tb_rf_writeback_arbiter;

    localparam int LQ_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        lresp_valid;
    logic        lresp_ready;
    logic [4:0]  lresp_rd;
    logic [31:0] lresp_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic [1:0]  lq_count;
    logic        err_waw;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          mq_rd[$];
    logic [31:0] mq_data[$];
    logic [31:0] mbusy;
    logic        merr;
    logic        mwe;
    logic [4:0]  maddr;
    logic [31:0] mdata;

    rf_writeback_arbiter #(
        .XLEN     (32),
        .LQ_DEPTH (LQ_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .lresp_valid    (lresp_valid),
        .lresp_ready    (lresp_ready),
        .lresp_rd       (lresp_rd),
        .lresp_data     (lresp_data),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .busy           (busy),
        .lq_count       (lq_count),
        .err_waw        (err_waw)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic iv, input logic [4:0] ird,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid      = av;
        alu_rd         = ard;
        alu_data       = ad;
        ld_issue_valid = iv;
        ld_issue_rd    = ird;
        lresp_valid    = lv;
        lresp_rd       = lrd;
        lresp_data     = ld;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic modelReset();
        mq_rd.delete();
        mq_data.delete();
        mbusy = '0;
        merr  = 1'b0;
        mwe   = 1'b0;
        maddr = '0;
        mdata = '0;
    endtask

    task automatic checkOutput();
        chk("rf_we", rf_we, mwe);
        chk("rf_waddr", rf_waddr, maddr);
        chk("rf_wdata", rf_wdata, mdata);
        chk("busy", busy, mbusy);
        chk("lq_count", lq_count, mq_rd.size());
        chk("err_waw", err_waw, merr);
    endtask

    // One clock: check handshake outputs, advance the model by the rules
    // (ALU > queue head > bypass), clock the DUT and compare all outputs.
    task automatic tick();
        logic        alu_ok;
        logic        acc;
        logic        lw;
        logic        byp;
        logic [31:0] nbusy;
        #1;
        chk("lresp_ready", lresp_ready, mq_rd.size() < LQ_DEPTH);
        chk("ld_issue_ready", ld_issue_ready, !mbusy[ld_issue_rd]);
        alu_ok = alu_valid && alu_rd != 0;
        acc    = lresp_valid && (mq_rd.size() < LQ_DEPTH);
        lw     = 1'b0;
        byp    = 1'b0;
        nbusy  = mbusy;
        if (alu_ok && mbusy[alu_rd]) merr = 1'b1;
        if (alu_ok) begin
            mwe = 1'b1; maddr = alu_rd; mdata = alu_data;
        end else if (mq_rd.size() > 0) begin
            mwe = 1'b1; maddr = 5'(mq_rd.pop_front()); mdata = mq_data.pop_front(); lw = 1'b1;
        end else if (acc && lresp_rd != 0) begin
            mwe = 1'b1; maddr = lresp_rd; mdata = lresp_data; lw = 1'b1; byp = 1'b1;
        end else begin
            mwe = 1'b0;
        end
        if (acc && lresp_rd != 0 && !byp) begin
            mq_rd.push_back(int'(lresp_rd));
            mq_data.push_back(lresp_data);
        end
        if (lw) nbusy[maddr] = 1'b0;
        if (ld_issue_valid && ld_issue_rd != 0 && !mbusy[ld_issue_rd]) nbusy[ld_issue_rd] = 1'b1;
        mbusy = nbusy;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        modelReset();
        idle();
        rst = 1'b1;
        #2;
        checkOutput();
        chk("reset lresp_ready", lresp_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 2: basic ALU write, one-cycle pulse
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        tick();
        chk("alu we", rf_we, 1);
        chk("alu waddr", rf_waddr, 5);
        chk("alu wdata", rf_wdata, 32'hDEADBEEF);
        idle();
        tick();
        chk("alu we drop", rf_we, 0);

        // Test 3: load round trip through the bypass
        applyStimulus(0, 0, 0, 1, 7, 0, 0, 0);
        tick();
        chk("busy7 set", busy[7], 1);
        applyStimulus(0, 0, 0, 1, 7, 0, 0, 0);
        #1;
        chk("r7 not ready", ld_issue_ready, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 7, 32'h1234);
        tick();
        chk("byp we", rf_we, 1);
        chk("byp waddr", rf_waddr, 7);
        chk("byp wdata", rf_wdata, 32'h1234);
        chk("busy7 clr", busy[7], 0);

        // Test 4: ALU stream collides with back-to-back responses
        applyStimulus(0, 0, 0, 1, 3, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 1, 4, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 1, 6, 0, 0, 0); tick();
        applyStimulus(1, 10, 32'hA0, 0, 0, 1, 3, 32'h33); tick();
        applyStimulus(1, 11, 32'hA1, 0, 0, 1, 4, 32'h44); tick();
        chk("lq full count", lq_count, 2);
        applyStimulus(1, 12, 32'hA2, 0, 0, 1, 6, 32'h66);
        #1;
        chk("lq full ready", lresp_ready, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 6, 32'h66); tick();
        chk("drain r3", rf_waddr, 3);
        chk("drain d3", rf_wdata, 32'h33);
        tick();
        chk("drain r4", rf_waddr, 4);
        idle(); tick();
        chk("drain r6", rf_waddr, 6);
        chk("drain d6", rf_wdata, 32'h66);
        chk("drain busy", busy, 0);
        idle(); tick();

        // Test 5: x0 discard and WAW hazard flag
        applyStimulus(1, 0, 32'h5, 0, 0, 1, 0, 32'h6); tick();
        chk("x0 we", rf_we, 0);
        chk("x0 busy", busy[0], 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0); tick();
        chk("x0 issue busy", busy, 0);
        applyStimulus(0, 0, 0, 1, 9, 0, 0, 0); tick();
        applyStimulus(1, 9, 32'h99, 0, 0, 0, 0, 0); tick();
        chk("waw set", err_waw, 1);
        chk("waw busy kept", busy[9], 1);
        idle(); tick(); tick();
        chk("waw sticky", err_waw, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 9, 32'h9); tick();

        // Test 6: load write to r2 in the same cycle a new load to r2 issues
        applyStimulus(0, 0, 0, 1, 2, 1, 2, 32'h22); tick();
        chk("setclr we", rf_waddr, 2);
        chk("setclr busy2", busy[2], 1);
        idle(); tick();

        // Test 1: reset with two responses queued
        applyStimulus(1, 13, 32'hB0, 1, 11, 1, 11, 32'hC0); tick();
        applyStimulus(1, 14, 32'hB1, 0, 0, 1, 12, 32'hC1); tick();
        chk("pre-reset count", lq_count, 2);
        idle();
        rst = 1'b1;
        #1;
        modelReset();
        chk("rst we", rf_we, 0);
        chk("rst count", lq_count, 0);
        chk("rst busy", busy, 0);
        chk("rst ready", lresp_ready, 1);
        chk("rst err", err_waw, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput();

        // Randomized phase; a stalled response is held by its source.
        for (int i = 0; i < 400; i++) begin
            if (!(lresp_valid && mq_rd.size() >= LQ_DEPTH)) begin
                lresp_valid = 1'($urandom_range(0, 1));
                lresp_rd    = 5'($urandom_range(0, 7));
                lresp_data  = $urandom;
            end
            alu_valid      = ($urandom_range(0, 2) == 0);
            alu_rd         = 5'($urandom_range(0, 7));
            alu_data       = $urandom;
            ld_issue_valid = 1'($urandom_range(0, 1));
            ld_issue_rd    = 5'($urandom_range(0, 7));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
